moving_avg_filt: RTL and testbench

MOVING_AVG_FILT -- requirements
Module: moving_avg_filt

---
 rtl/moving_avg_pkg.sv | 14 +
 rtl/movavg_ring_buf.sv | 26 ++
 rtl/moving_avg_filt.sv | 102 ++++++++++
 tb/tb_moving_avg_filt.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/moving_avg_pkg.sv
// Shared defaults for the moving-average filter and its running-sum width helper.
package moving_avg_pkg;

  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefLog2Depth = 5;
  localparam int unsigned DefOutlierTh = 16;

  // The sum of 2**log2_depth samples of data_w bits fits in data_w + log2_depth bits.
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage

// File: rtl/movavg_ring_buf.sv
// Sample window storage: combinational read and synchronous write at the same pointer.
module movavg_ring_buf
  import moving_avg_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned LOG2_DEPTH = DefLog2Depth
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**LOG2_DEPTH];

  // No reset: stale entries are never subtracted until the window has refilled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/moving_avg_filt.sv
// Boxcar moving-average filter over a 2**LOG2_DEPTH sample window.
// Optional outlier clamp enabled by defining MOVING_AVG_OUTLIER_CLAMP_EN.
module moving_avg_filt
  import moving_avg_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned LOG2_DEPTH = DefLog2Depth,
  parameter int unsigned OUTLIER_TH = DefOutlierTh
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] raw_in,
  input  logic              in_valid,
  input  logic              flush,
  output logic [DATA_W-1:0] avg_out,
  output logic              out_valid,
  output logic              filled
);

  localparam int unsigned SUM_W = sum_width(DATA_W, LOG2_DEPTH);
  localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;
  localparam int unsigned CNT_W = LOG2_DEPTH + 1;

  if (OUTLIER_TH > 2 ** DATA_W - 1) begin : g_th_range
    $error("OUTLIER_TH exceeds the sample range");
  end

  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q;
  logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0]     avg_q;
  logic                  out_valid_q;
  logic [DATA_W-1:0]     sample;
  logic [DATA_W-1:0]     oldest;
  logic                  accept;

  assign accept = in_valid & ~flush;
  assign filled = (fill_cnt_q == CNT_W'(DEPTH));

`ifdef MOVING_AVG_OUTLIER_CLAMP_EN
  localparam logic [DATA_W:0] ThExt  = (DATA_W + 1)'(OUTLIER_TH);
  localparam logic [DATA_W:0] MaxExt = {1'b0, {DATA_W{1'b1}}};

  logic [DATA_W:0] avg_ext, raw_ext, lo, hi;

  always_comb begin
    avg_ext = {1'b0, avg_q};
    raw_ext = {1'b0, raw_in};
    lo      = (avg_ext > ThExt) ? avg_ext - ThExt : '0;
    hi      = (avg_ext + ThExt > MaxExt) ? MaxExt : avg_ext + ThExt;
    sample  = raw_in;
    if (filled) begin
      if (raw_ext < lo) begin
        sample = lo[DATA_W-1:0];
      end else if (raw_ext > hi) begin
        sample = hi[DATA_W-1:0];
      end
    end
  end
`else
  assign sample = raw_in;
`endif

  movavg_ring_buf #(
    .DATA_W    (DATA_W),
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_ring_buf (
    .clk  (clk),
    .we   (accept),
    .addr (wr_ptr_q),
    .wdata(sample),
    .rdata(oldest)
  );

  // Until filled, the slot at wr_ptr is stale and must not be subtracted.
  always_comb begin
    sum_d      = sum_q + SUM_W'(sample) - (filled ? SUM_W'(oldest) : '0);
    fill_cnt_d = filled ? fill_cnt_q : fill_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      avg_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (in_valid) begin
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_q + 1'b1;
      fill_cnt_q  <= fill_cnt_d;
      avg_q       <= DATA_W'(sum_d >> LOG2_DEPTH);
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign avg_out   = avg_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_moving_avg_filt.sv
// Scoreboard bench for moving_avg_filt; expected values come from a behavioural window model.
module tb_moving_avg_filt;

  localparam int DEPTH = 32;
  localparam int TH    = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] raw_in = 8'd0;
  logic [7:0] avg_out;
  logic       out_valid;
  logic       filled;

  always #5 clk = ~clk;

  moving_avg_filt #(
    .DATA_W    (8),
    .LOG2_DEPTH(5),
    .OUTLIER_TH(TH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (raw_in),
    .in_valid (in_valid),
    .flush    (flush),
    .avg_out  (avg_out),
    .out_valid(out_valid),
    .filled   (filled)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int m_buf[DEPTH];
  int m_sum = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_avg = 0;
  bit mon_en = 1'b0;
  int ov_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp_sample(input int s);
    int v;
    v = s;
`ifdef MOVING_AVG_OUTLIER_CLAMP_EN
    if (m_cnt == DEPTH) begin
      int lo, hi;
      lo = (m_avg > TH) ? m_avg - TH : 0;
      hi = (m_avg + TH > 255) ? 255 : m_avg + TH;
      if (v < lo) v = lo;
      else if (v > hi) v = hi;
    end
`endif
    return v;
  endfunction

  task automatic model_clear();
    m_sum = 0;
    m_ptr = 0;
    m_cnt = 0;
    m_avg = 0;
  endtask

  task automatic drive(input int s);
    int v;
    @(negedge clk);
    #1;
    raw_in   = 8'(s);
    in_valid = 1'b1;
    flush    = 1'b0;
    v        = clamp_sample(s);
    m_sum    = m_sum + v - ((m_cnt == DEPTH) ? m_buf[m_ptr] : 0);
    m_buf[m_ptr] = v;
    m_ptr    = (m_ptr + 1) % DEPTH;
    if (m_cnt < DEPTH) m_cnt++;
    m_avg    = m_sum / DEPTH;
    exp_q.push_back(m_avg);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    model_clear();
    exp_q.delete();
    mon_en   = 1'b1;
    @(negedge clk);
    #1;
    reset    = 1'b0;
  endtask

  task automatic flush_with_sample(input int s);
    @(negedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    raw_in   = 8'(s);
    model_clear();
  endtask

  // Every cycle: pulse timing, scoreboard pop, hold behaviour and filled flag.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid) begin
        ov_count++;
        if (exp_q.size() != 0) check_eq("sb_avg", avg_out, exp_q.pop_front());
      end
      check_eq("avg_hold", avg_out, m_avg);
      check_eq("filled", filled, m_cnt == DEPTH);
    end
  end

  initial begin
    do_reset();
    idle(1);
    check_eq("rst_avg", avg_out, 0);
    check_eq("rst_ov", out_valid, 0);
    check_eq("rst_filled", filled, 0);

    for (int i = 1; i <= 32; i++) drive(i);
    idle(1);
    check_eq("ramp_sum32", dut.sum_q, 528);
    check_eq("ramp_avg32", avg_out, 16);
    check_eq("ramp_filled", filled, 1);
    drive(33);
    idle(1);
    check_eq("ramp_sum33", dut.sum_q, 560);
    check_eq("ramp_avg33", avg_out, 17);

    do_reset();
    for (int i = 1; i <= 64; i++) begin
      drive(55);
      if (i == 32) begin
        idle(1);
        check_eq("conv_avg32", avg_out, 55);
      end
    end
    idle(1);
    check_eq("conv_avg64", avg_out, 55);
    check_eq("conv_sum", dut.sum_q, 1760);

    drive(200);
    idle(1);
`ifdef MOVING_AVG_OUTLIER_CLAMP_EN
    check_eq("outlier_stored", dut.u_ring_buf.mem[0], 71);
    check_eq("outlier_sum", dut.sum_q, 1776);
    check_eq("outlier_avg", avg_out, 55);
`else
    check_eq("outlier_stored", dut.u_ring_buf.mem[0], 200);
    check_eq("outlier_sum", dut.sum_q, 1905);
    check_eq("outlier_avg", avg_out, 59);
`endif

    do_reset();
    ov_count = 0;
    drive(10);
    idle(3);
    drive(20);
    idle(3);
    check_eq("gap_pulses", ov_count, 2);
    check_eq("gap_sum", dut.sum_q, 30);

    do_reset();
    for (int i = 0; i < 40; i++) drive(255);
    idle(1);
    check_eq("wide_sum", dut.sum_q, 8160);
    check_eq("wide_avg", avg_out, 255);
    check_eq("wide_ptr", dut.wr_ptr_q, 8);

    do_reset();
    for (int i = 0; i < 20; i++) drive(55);
    do_reset();
    check_eq("midrst_avg", avg_out, 0);
    check_eq("midrst_filled", filled, 0);
    drive(100);
    idle(1);
    check_eq("midrst_first", avg_out, 3);

    for (int i = 0; i < 5; i++) drive(80);
    flush_with_sample(99);
    idle(1);
    check_eq("flush_ov", out_valid, 0);
    check_eq("flush_sum", dut.sum_q, 0);
    check_eq("flush_avg", avg_out, 0);
    check_eq("flush_ptr", dut.wr_ptr_q, 0);
    drive(7);
    idle(1);
    check_eq("post_flush_sum", dut.sum_q, 7);
    check_eq("post_flush_avg", avg_out, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
